// File: rtl/data_bus_mmio_if.sv
// CPU data-port bus bundle: byte address, store data/strobes, load strobe and
// the combinational read data returned by the bus stage.
interface data_bus_mmio_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;

  modport master (
    output cpu_addr, cpu_wdata, cpu_wren, cpu_rden, cpu_be,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wren, cpu_rden, cpu_be,
    output cpu_rdata
  );
endinterface

// File: rtl/data_bus_mmio.sv
// Data-side bus stage: decodes CPU loads/stores into data RAM, LED register,
// keyboard scan-code FIFO and compare timer, with zero-latency read data.
module data_bus_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  data_bus_mmio_if.slave      bus,
  input  logic                key_valid,
  input  logic [7:0]          key_data,
  output logic                key_ready,
  output logic [15:0]         led,
  output logic                timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [29:0] IO_BASE = 30'h0400_0000;

  typedef enum logic [2:0] {
    SEL_LED   = 3'd0,
    SEL_KSTAT = 3'd1,
    SEL_KDATA = 3'd2,
    SEL_TCNT  = 3'd3,
    SEL_TCMP  = 3'd4,
    SEL_TCTRL = 3'd5,
    SEL_RSVD6 = 3'd6,
    SEL_RSVD7 = 3'd7
  } reg_sel_e;

  logic [29:0]   word;
  logic          ram_hit;
  logic          io_hit;
  reg_sel_e      sel;
  logic [AW-1:0] ram_idx;

  logic wr_ram, wr_led, wr_kstat, wr_tcnt, wr_tcmp, wr_tctrl, rd_kdata;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   led_q, led_d;
  logic [31:0]   tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic          ten_q, ten_d, tpend_q, tpend_d;

  logic nonempty, full, push, pop, match;
  logic unused_addr_bits;

  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign word    = bus.cpu_addr[31:2];
  assign ram_hit = (word[29:AW] == '0);
  assign io_hit  = (word[29:3] == IO_BASE[29:3]);
  assign sel     = reg_sel_e'(word[2:0]);
  assign ram_idx = word[AW-1:0];

  always_comb begin
    wr_ram   = 1'b0;
    wr_led   = 1'b0;
    wr_kstat = 1'b0;
    wr_tcnt  = 1'b0;
    wr_tcmp  = 1'b0;
    wr_tctrl = 1'b0;
    rd_kdata = 1'b0;
    if (ram_hit) begin
      wr_ram = bus.cpu_wren;
    end else if (io_hit) begin
      case (sel)
        SEL_LED:   wr_led   = bus.cpu_wren;
        SEL_KSTAT: wr_kstat = bus.cpu_wren;
        SEL_KDATA: rd_kdata = bus.cpu_rden;
        SEL_TCNT:  wr_tcnt  = bus.cpu_wren;
        SEL_TCMP:  wr_tcmp  = bus.cpu_wren;
        SEL_TCTRL: wr_tctrl = bus.cpu_wren;
        default:   ;
      endcase
    end
  end

  assign nonempty = (count_q != 5'd0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = rd_kdata && nonempty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push     = key_valid && (!full || pop);
  assign match    = ten_q && (tcnt_q == tcmp_q);

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + {4'b0, push} - {4'b0, pop};
    ovf_d   = (ovf_q && !(wr_kstat && bus.cpu_wdata[2])) || (key_valid && full && !pop);

    led_d  = wr_led  ? bus.cpu_wdata[15:0] : led_q;
    tcmp_d = wr_tcmp ? bus.cpu_wdata       : tcmp_q;
    ten_d  = wr_tctrl ? bus.cpu_wdata[0]   : ten_q;

    tcnt_d = tcnt_q;
    if (wr_tcnt)    tcnt_d = bus.cpu_wdata;
    else if (match) tcnt_d = '0;
    else if (ten_q) tcnt_d = tcnt_q + 32'd1;

    // Setting on a match outranks a same-cycle write-1-to-clear.
    tpend_d = match || (tpend_q && !(wr_tctrl && bus.cpu_wdata[1]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      led_q   <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= '1;
      ten_q   <= 1'b0;
      tpend_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      ten_q   <= ten_d;
      tpend_q <= tpend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ram) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.cpu_be[i]) ram[ram_idx][8*i +: 8] <= bus.cpu_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[tail_q] <= key_data;
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (ram_hit) begin
      bus.cpu_rdata = ram[ram_idx];
    end else if (io_hit) begin
      case (sel)
        SEL_LED:   bus.cpu_rdata = {16'b0, led_q};
        SEL_KSTAT: bus.cpu_rdata = {23'b0, count_q, 1'b0, ovf_q, full, nonempty};
        SEL_KDATA: bus.cpu_rdata = nonempty ? {23'b0, 1'b1, fifo_mem[head_q]} : '0;
        SEL_TCNT:  bus.cpu_rdata = tcnt_q;
        SEL_TCMP:  bus.cpu_rdata = tcmp_q;
        SEL_TCTRL: bus.cpu_rdata = {30'b0, tpend_q, ten_q};
        default:   bus.cpu_rdata = '0;
      endcase
    end
  end

  assign key_ready = !full;
  assign led       = led_q;
  assign timer_irq = tpend_q;

endmodule

// File: tb/tb_data_bus_mmio.sv
// Bench for data_bus_mmio: directed scenarios plus random traffic, checked
// against a transaction-level model (queue FIFO, plain-integer timer).
module tb_data_bus_mmio;

  localparam logic [31:0] A_LED   = 32'h1000_0000;
  localparam logic [31:0] A_KSTAT = 32'h1000_0004;
  localparam logic [31:0] A_KDATA = 32'h1000_0008;
  localparam logic [31:0] A_TCNT  = 32'h1000_000C;
  localparam logic [31:0] A_TCMP  = 32'h1000_0010;
  localparam logic [31:0] A_TCTRL = 32'h1000_0014;
  localparam logic [31:0] A_IDLE  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_data;
  logic        key_ready;
  logic [15:0] led;
  logic        timer_irq;

  data_bus_mmio_if bus ();

  data_bus_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .led       (led),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: RAM window of 16 words, FIFO as a queue
  logic [31:0] m_ram [16];
  logic [7:0]  m_q [$];
  logic [15:0] m_led;
  bit          m_ovf;
  logic [31:0] m_tcnt, m_tcmp;
  bit          m_ten, m_tpend;

  logic [31:0] last_rd;
  logic        last_irq, last_ready;
  logic [15:0] last_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] wa;
    int          n;
    wa = {a[31:2], 2'b00};
    n  = m_q.size();
    if (wa < 32'h40) return m_ram[wa[5:2]];
    case (wa)
      A_LED:   return {16'b0, m_led};
      A_KSTAT: return (n << 4) | (32'(m_ovf) << 2) | (32'(n == 16) << 1) | 32'(n > 0);
      A_KDATA: return (n > 0) ? (32'h100 | 32'(m_q[0])) : 32'h0;
      A_TCNT:  return m_tcnt;
      A_TCMP:  return m_tcmp;
      A_TCTRL: return (32'(m_tpend) << 1) | 32'(m_ten);
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ovf = 0; m_led = '0; m_tcnt = '0; m_tcmp = '1; m_ten = 0; m_tpend = 0;
  endtask

  task automatic m_step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic re, input logic [3:0] be, input logic kv,
                        input logic [7:0] kd, input logic r);
    logic [31:0] wa;
    bit          was_full, do_pop, hit;
    if (r) begin
      m_reset();
      return;
    end
    wa       = {a[31:2], 2'b00};
    was_full = (m_q.size() == 16);
    do_pop   = re && (wa == A_KDATA) && (m_q.size() > 0);
    hit      = m_ten && (m_tcnt == m_tcmp);
    if (do_pop) void'(m_q.pop_front());
    if (kv && (!was_full || do_pop)) m_q.push_back(kd);
    if (we && wa == A_KSTAT && wd[2]) m_ovf = 0;
    if (kv && was_full && !do_pop) m_ovf = 1;
    if (we && wa == A_TCNT) m_tcnt = wd;
    else if (hit) m_tcnt = 0;
    else if (m_ten) m_tcnt = m_tcnt + 1;
    if (we && wa == A_TCTRL && wd[1]) m_tpend = 0;
    if (hit) m_tpend = 1;
    if (we && wa == A_TCTRL) m_ten = wd[0];
    if (we && wa == A_TCMP) m_tcmp = wd;
    if (we && wa == A_LED) m_led = wd[15:0];
    if (we && wa < 32'h40)
      for (int i = 0; i < 4; i++)
        if (be[i]) m_ram[wa[5:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic re, input logic [3:0] be, input logic kv,
                     input logic [7:0] kd, input logic r);
    bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_wren = we; bus.cpu_rden = re;
    bus.cpu_be = be; key_valid = kv; key_data = kd; rst = r;
    #4;
    last_rd = bus.cpu_rdata; last_irq = timer_irq; last_ready = key_ready; last_led = led;
    chk("rdata", last_rd, m_read(a));
    chk("key_ready", {31'b0, last_ready}, {31'b0, m_q.size() != 16});
    chk("led", {16'b0, last_led}, {16'b0, m_led});
    chk("timer_irq", {31'b0, last_irq}, {31'b0, m_tpend});
    @(posedge clk);
    m_step(a, wd, we, re, be, kv, kd, r);
    #1;
  endtask

  task automatic idle();                      cyc(A_IDLE, '0, 0, 0, '0, 0, '0, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); cyc(a, d, 1, 0, 4'hF, 0, '0, 0); endtask
  task automatic rd(input logic [31:0] a);    cyc(a, '0, 0, 1, '0, 0, '0, 0); endtask
  task automatic push(input logic [7:0] k);   cyc(A_IDLE, '0, 0, 0, '0, 1, k, 0); endtask

  logic [31:0] saved;

  initial begin
    bus.cpu_addr = A_IDLE; bus.cpu_wdata = '0; bus.cpu_wren = 0; bus.cpu_rden = 0;
    bus.cpu_be = '0; key_valid = 0; key_data = '0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 0;

    chk("reset_kstat", m_read(A_KSTAT), 32'h0);
    rd(A_TCMP);
    chk("reset_tcmp", last_rd, 32'hFFFF_FFFF);
    chk("reset_ready", {31'b0, last_ready}, 32'h1);

    for (int i = 0; i < 16; i++) wr(32'(4 * i), $urandom);

    wr(32'h10, 32'hDEAD_BEEF);
    cyc(32'h10, 32'h5555_5555, 1, 0, 4'b0100, 0, '0, 0);
    rd(32'h10);
    chk("ram_byte", last_rd, 32'hDE55_BEEF);
    rd(32'h2000_0000);
    chk("unmapped", last_rd, 32'h0);

    for (int i = 1; i <= 16; i++) push(8'(i));
    rd(A_KSTAT);
    chk("kstat_full", last_rd, 32'h103);
    chk("ready_full", {31'b0, last_ready}, 32'h0);
    push(8'h11);
    rd(A_KSTAT);
    chk("kstat_ovf", last_rd, 32'h107);
    for (int i = 1; i <= 16; i++) begin
      rd(A_KDATA);
      chk("pop_order", last_rd, 32'h100 + 32'(i));
    end
    rd(A_KDATA);
    chk("empty_read", last_rd, 32'h0);

    for (int i = 1; i <= 16; i++) push(8'(8'h20 + i));
    cyc(A_KDATA, '0, 0, 1, '0, 1, 8'h77, 0);
    chk("pushpop_head", last_rd, 32'h121);
    rd(A_KSTAT);
    chk("pushpop_count", last_rd, 32'h107);
    for (int i = 1; i <= 16; i++) begin
      rd(A_KDATA);
      if (i == 16) chk("pushpop_last", last_rd, 32'h177);
    end
    wr(A_KSTAT, 32'h4);
    rd(A_KSTAT);
    chk("ovf_clear", last_rd, 32'h0);

    wr(A_TCMP, 32'd3);
    wr(A_TCNT, 32'd0);
    wr(A_TCTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      rd(A_TCNT);
      chk("tcount_seq", last_rd, 32'(i % 4));
      if (i == 3) chk("irq_before", {31'b0, last_irq}, 32'h0);
      if (i == 4) chk("irq_rise", {31'b0, last_irq}, 32'h1);
    end
    wr(A_TCTRL, 32'h2);
    idle();
    chk("irq_clear", {31'b0, last_irq}, 32'h0);
    wr(A_TCTRL, 32'h1);
    idle();
    wr(A_TCTRL, 32'h3);
    rd(A_TCTRL);
    chk("irq_set_wins", {31'b0, last_irq}, 32'h1);
    chk("tctrl_read", last_rd, 32'h3);

    wr(A_TCMP, 32'd1000);
    wr(A_TCTRL, 32'h3);
    for (int i = 0; i < 5; i++) push(8'($urandom));
    wr(A_LED, 32'h0000_ABCD);
    idle();
    saved = m_ram[5];
    cyc(32'h14, 32'h1234_5678, 1, 0, 4'hF, 1, 8'h99, 1);
    rd(A_KSTAT);
    chk("rst_kstat", last_rd, 32'h0);
    chk("rst_led", {16'b0, last_led}, 32'h0);
    chk("rst_irq", {31'b0, last_irq}, 32'h0);
    rd(A_TCNT);
    chk("rst_tcnt", last_rd, 32'h0);
    rd(32'h14);
    chk("rst_ram_kept", last_rd, saved);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d;
      logic        r;
      case ($urandom_range(0, 9))
        0, 1:    a = 32'(4 * $urandom_range(0, 15));
        2:       a = A_LED;
        3:       a = A_KSTAT;
        4, 5:    a = A_KDATA;
        6:       a = A_TCNT;
        7:       a = A_TCMP;
        8:       a = A_TCTRL;
        default: a = 32'h2000_0000;
      endcase
      d = (a == A_TCNT || a == A_TCMP) ? 32'($urandom_range(0, 20)) : $urandom;
      r = ($urandom_range(0, 63) == 0);
      cyc(a, d, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, 4'($urandom),
          $urandom_range(0, 1) == 1, 8'($urandom), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
